// File: rtl/gba_video_pkg.sv
// Shared GBA video types, screen geometry and the BGR555 -> RGB6 colour conversion.
// GBA_LCD_DARKEN_EN selects LCD-style darkening of each channel instead of plain bit replication.
package gba_video_pkg;

  localparam int GBA_WIDTH  = 240;
  localparam int GBA_HEIGHT = 160;

  typedef struct packed {
    logic [4:0] b;
    logic [4:0] g;
    logic [4:0] r;
  } bgr555_t;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } rgb6_t;

  // FIFO entry: start-of-frame marker alongside the raw pixel.
  typedef struct packed {
    logic    sof;
    bgr555_t pix;
  } lcd_entry_t;

  function automatic logic [5:0] expand_c5(input logic [4:0] c5);
    logic [5:0] r6;
    r6 = {c5, c5[4]};
`ifdef GBA_LCD_DARKEN_EN
    return r6 - (r6 >> 3);
`else
    return r6;
`endif
  endfunction

  function automatic rgb6_t bgr555_to_rgb6(input bgr555_t p);
    rgb6_t o;
    o.r = expand_c5(p.r);
    o.g = expand_c5(p.g);
    o.b = expand_c5(p.b);
    return o;
  endfunction

endpackage

// File: rtl/gba_lcd_fifo.sv
// Synchronous FIFO with a registered occupancy count and full/empty flags.
// Storage is a plain array without reset so it maps onto distributed RAM.
module gba_lcd_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gba_lcd_writer.sv
// Buffers the PPU BGR555 pixel stream and writes RGB6 pixels with (x,y) into the frame buffer.
// Colour path honours GBA_LCD_DARKEN_EN (see gba_video_pkg); latency is the same either way.
module gba_lcd_writer
  import gba_video_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int WIDTH      = GBA_WIDTH,
  parameter int HEIGHT     = GBA_HEIGHT
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [14:0] in_data,
  input  logic        in_sof,
  input  logic        sink_busy,
  output logic        pixel_we,
  output logic [7:0]  pixel_x,
  output logic [7:0]  pixel_y,
  output logic [17:0] pixel_data,
  output logic        frame_done,
  output logic        resync_err
);

  // Handshake: a pixel transfers on every rising edge where in_valid & in_ready;
  // in_valid may not depend on in_ready, and in_ready only reflects the registered
  // FIFO count, so a pop in the same cycle never opens a slot early.

  lcd_entry_t push_entry;
  lcd_entry_t head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;

  logic [7:0] next_x;
  logic [7:0] next_y;
  logic [7:0] cur_x;
  logic [7:0] cur_y;
  logic [7:0] adv_x;
  logic [7:0] adv_y;
  logic       at_line_end;
  logic       at_frame_end;
  logic       sof_bad;

  assign in_ready       = resetn && !fifo_full;
  assign push           = in_valid && in_ready;
  assign pop            = !fifo_empty && !sink_busy;
  assign push_entry.sof = in_sof;
  assign push_entry.pix = bgr555_t'(in_data);

  gba_lcd_fifo #(
    .WIDTH ($bits(lcd_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Position of the head pixel: sof forces (0,0), otherwise the tracked next position.
  always_comb begin
    cur_x        = next_x;
    cur_y        = next_y;
    adv_x        = '0;
    adv_y        = '0;
    at_line_end  = 1'b0;
    at_frame_end = 1'b0;
    sof_bad      = 1'b0;
    if (head.sof) begin
      cur_x   = '0;
      cur_y   = '0;
      sof_bad = (next_x != '0) || (next_y != '0);
    end
    at_line_end  = (cur_x == 8'(WIDTH - 1));
    at_frame_end = at_line_end && (cur_y == 8'(HEIGHT - 1));
    if (!at_line_end) begin
      adv_x = cur_x + 8'd1;
      adv_y = cur_y;
    end else if (!at_frame_end) begin
      adv_y = cur_y + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      next_x     <= '0;
      next_y     <= '0;
      pixel_we   <= 1'b0;
      pixel_x    <= '0;
      pixel_y    <= '0;
      pixel_data <= '0;
      frame_done <= 1'b0;
      resync_err <= 1'b0;
    end else begin
      pixel_we   <= pop;
      frame_done <= pop && at_frame_end;
      if (pop) begin
        pixel_x    <= cur_x;
        pixel_y    <= cur_y;
        pixel_data <= bgr555_to_rgb6(head.pix);
        next_x     <= adv_x;
        next_y     <= adv_y;
        resync_err <= resync_err || sof_bad;
      end
    end
  end

endmodule

// File: tb/tb_gba_lcd_writer.sv
// Self-checking bench for gba_lcd_writer: directed stimulus, expected-write queue and a monitor.
// Honours GBA_LCD_DARKEN_EN for expected colours.
module tb_gba_lcd_writer;

  localparam int W  = 240;
  localparam int H  = 160;
  localparam int EW = 36;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [14:0] in_data = '0;
  logic        in_sof = 1'b0;
  logic        sink_busy = 1'b0;
  logic        pixel_we;
  logic [7:0]  pixel_x;
  logic [7:0]  pixel_y;
  logic [17:0] pixel_data;
  logic        frame_done;
  logic        resync_err;

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  logic [7:0]  m_x = '0;
  logic [7:0]  m_y = '0;
  logic        m_err = 1'b0;
  int          accepts = 0;
  int          we_count = 0;
  int          fd_count = 0;
  logic [7:0]  last_x = '0;
  logic [7:0]  last_y = '0;
  logic [17:0] last_data = '0;

  gba_lcd_writer dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sof     (in_sof),
    .sink_busy  (sink_busy),
    .pixel_we   (pixel_we),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .pixel_data (pixel_data),
    .frame_done (frame_done),
    .resync_err (resync_err)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] exp_c6(input logic [4:0] c);
    logic [5:0] v;
    v = {c, c[4]};
`ifdef GBA_LCD_DARKEN_EN
    v = v - {3'b000, v[5:3]};
`endif
    return v;
  endfunction

  // reference model of position tracking, evaluated at each accepted pixel
  task automatic model_accept(input logic [14:0] d, input logic sof);
    logic [7:0]  x;
    logic [7:0]  y;
    logic        fd;
    logic [17:0] rgb;
    if (sof) begin
      if (m_x != 0 || m_y != 0) m_err = 1'b1;
      x = 8'd0;
      y = 8'd0;
    end else begin
      x = m_x;
      y = m_y;
    end
    fd  = (x == 8'(W - 1)) && (y == 8'(H - 1));
    rgb = {exp_c6(d[4:0]), exp_c6(d[9:5]), exp_c6(d[14:10])};
    exp_q.push_back({x, y, rgb, fd, m_err});
    if (x == 8'(W - 1)) begin
      m_x = 8'd0;
      m_y = (y == 8'(H - 1)) ? 8'd0 : y + 8'd1;
    end else begin
      m_x = x + 8'd1;
      m_y = y;
    end
  endtask

  // driver tasks
  task automatic send(input logic [14:0] d, input logic sof);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    for (int n = 0; n < 5000 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(d, sof);
        accepts++;
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout in_ready stuck at 0, required 1");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending %0d required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    exp_q.delete();
    m_x   = '0;
    m_y   = '0;
    m_err = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_we", 64'(pixel_we), 64'd0);
    check("reset_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (resetn) begin
      if (frame_done && !pixel_we) begin
        checks++;
        failures++;
        $display("FAIL frame_done_without_we got 1 required 0");
      end
      if (pixel_we) begin
        we_count++;
        last_x    = pixel_x;
        last_y    = pixel_y;
        last_data = pixel_data;
        if (frame_done) fd_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write x=%0d y=%0d required no write", pixel_x, pixel_y);
        end else begin
          check("pixel_write", 64'({pixel_x, pixel_y, pixel_data, frame_done, resync_err}),
                64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int w0;
    int win;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_outputs", 64'({pixel_we, pixel_x, pixel_y, pixel_data, frame_done, resync_err}), 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // single pixel: two-cycle latency, white
    send(15'h7FFF, 1'b1);
    idle();
    @(negedge clk);
    check("latency_t1_we", 64'(pixel_we), 64'd0);
    @(negedge clk);
    check("latency_t2_we", 64'(pixel_we), 64'd1);
    check("single_xy", 64'({pixel_x, pixel_y}), 64'd0);
`ifdef GBA_LCD_DARKEN_EN
    check("single_white", 64'(pixel_data), 64'h38E38);
`else
    check("single_white", 64'(pixel_data), 64'h3FFFF);
`endif
    drain();

    // colour mapping B=1 G=16 R=0
    send(15'h0600, 1'b0);
    idle();
    drain();
`ifdef GBA_LCD_DARKEN_EN
    check("colour_map", 64'(last_data), 64'h742);
`else
    check("colour_map", 64'(last_data), 64'h842);
`endif
    check("colour_map_xy", 64'({last_x, last_y}), 64'h0100);

    // full frame back-to-back
    do_reset();
    fd_count = 0;
    for (int i = 0; i < W * H; i++) send(15'(i * 7 + 3), i == 0);
    idle();
    drain();
    check("frame_last_xy", 64'({last_x, last_y}), 64'({8'd239, 8'd159}));
    send(15'h1234, 1'b1);
    idle();
    drain();
    check("frame_done_once", 64'(fd_count), 64'd1);
    check("frame_sof_xy", 64'({last_x, last_y}), 64'd0);
    check("frame_no_err", 64'(resync_err), 64'd0);

    // backpressure
    sink_busy = 1'b1;
    accepts = 0;
    w0 = we_count;
    fork
      begin
        for (int i = 0; i < 20; i++) send(15'(i + 100), 1'b0);
        idle();
      end
      begin
        repeat (100) @(posedge clk);
        #1;
        check("bp_accepts", 64'(accepts), 64'd16);
        check("bp_ready_low", 64'(in_ready), 64'd0);
        check("bp_no_writes", 64'(we_count - w0), 64'd0);
        sink_busy = 1'b0;
        @(posedge clk);
        win = 0;
        repeat (16) begin
          @(negedge clk);
          if (pixel_we) win++;
        end
        check("bp_burst_no_gaps", 64'(win), 64'd16);
      end
    join
    drain();

    // mid-frame sof on pixel 500
    do_reset();
    for (int i = 0; i < 510; i++) send(15'(i * 13), i == 0 || i == 500);
    idle();
    drain();
    check("midsof_err_sticky", 64'(resync_err), 64'd1);

    // reset mid-frame with queued pixels
    do_reset();
    check("err_cleared", 64'(resync_err), 64'd0);
    for (int i = 0; i < 1000; i++) send(15'(i * 5 + 1), i == 0);
    idle();
    sink_busy = 1'b1;
    for (int i = 0; i < 8; i++) send(15'(i + 7), 1'b0);
    idle();
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    sink_busy = 1'b0;
    w0 = we_count;
    repeat (10) @(posedge clk);
    #1;
    check("no_write_after_reset", 64'(we_count - w0), 64'd0);
    send(15'h2AAA, 1'b0);
    idle();
    drain();
    check("post_reset_xy", 64'({last_x, last_y}), 64'd0);
    check("post_reset_one_write", 64'(we_count - w0), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gba_lcd_writer.md
# gba_lcd_writer

Producer side of the frame-buffer pixel-write interface. It accepts the PPU's BGR555 pixel stream under a valid/ready handshake and buffers it in a small FIFO. It then emits one `pixel_we` write per pixel, with `pixel_x`, `pixel_y` and RGB6 `pixel_data`, into the HDMI converter's frame buffer. It holds writes while the sink is busy (frame-buffer background fill after reset) and resynchronises on start-of-frame.

## Interface
Parameters:
- `FIFO_DEPTH`, default 16: FIFO entries; power of two, at least 4.
- `WIDTH`, default 240: pixels per line.
- `HEIGHT`, default 160: lines per frame.

Ports:
- `clk`, in, 1: clock; same domain as the sink's write port.
- `resetn`, in, 1: reset, synchronous, active-low.
- `in_valid`, in, 1: PPU pixel valid.
- `in_ready`, out, 1: the block can accept a pixel.
- `in_data`, in, 15: BGR555; [4:0] R, [9:5] G, [14:10] B.
- `in_sof`, in, 1: the pixel is the first of a frame.
- `sink_busy`, in, 1: sink cannot take writes; hold output.
- `pixel_we`, out, 1: write strobe, one cycle per pixel.
- `pixel_x`, out, 8: column, 0..WIDTH-1.
- `pixel_y`, out, 8: line, 0..HEIGHT-1.
- `pixel_data`, out, 18: RGB6; [17:12] R, [11:6] G, [5:0] B.
- `frame_done`, out, 1: one-cycle pulse, coincident with the write of (WIDTH-1, HEIGHT-1).
- `resync_err`, out, 1: sticky; set when `in_sof` arrives at a position other than (0,0). Cleared only by reset.

## Operation
- Push: `in_valid & in_ready` writes {`in_sof`, `in_data`} into the FIFO.
- `in_ready` = resetn & (count != FIFO_DEPTH). It is computed from the registered count; a pop in the same cycle does not raise it.
- Pop: when the FIFO is not empty and `sink_busy` = 0, the head is popped, one per cycle.
- Popped pixel position: if its sof = 1, the position is (0,0). Otherwise it is the next position after the previous write.
- Position advance: x+1. At x = WIDTH-1, x wraps to 0 and y advances by 1. At (WIDTH-1, HEIGHT-1) both wrap to 0.
- `resync_err` is set when a popped pixel has sof = 1 and the expected next position is not (0,0).
- Colour conversion, per channel: c6 = {c5, c5[4]} (bit replication).
- Position counters reset to (0,0), so the first frame is also correct without an sof.
- Simultaneous push and pop: both happen and the count is unchanged. A push with the FIFO empty and a pop in the same cycle is not possible, because pop requires a non-empty FIFO at the cycle start (no bypass).
- `sink_busy` rising while data is queued: popping stops immediately. A write already registered still completes, since its `pixel_we` is already on the output.
- Reset mid-frame: the FIFO is flushed, counters return to (0,0), and `resync_err` is cleared.

## Timing
- Reset values: `in_ready` 0 while `resetn` = 0, then 1. `pixel_we` 0, `pixel_x` 0, `pixel_y` 0, `pixel_data` 0, `frame_done` 0, `resync_err` 0.
- Latency: a pixel accepted at cycle t into an empty FIFO, with `sink_busy` = 0, gives `pixel_we` = 1 at cycle t+2. The pop happens at t+1 and all outputs are registered.
- Throughput: one write per cycle sustained while `in_valid` = 1 and `sink_busy` = 0.
- Output hold: `pixel_x`, `pixel_y` and `pixel_data` keep their last values when `pixel_we` = 0.
- `frame_done` and `resync_err` are registered alongside `pixel_we`.
- The colour-conversion latency is identical with or without the macro.

## Configuration
- `GBA_LCD_DARKEN_EN` defined: LCD-style darkening, c6 = r6 - (r6 >> 3), with r6 = {c5, c5[4]}. Pure white 31 becomes 63 - 7 = 56; 0 stays 0. It is computed in the same registered output stage, with no added latency.
- `GBA_LCD_DARKEN_EN` undefined: plain bit replication; 31 becomes 63.

## Structure
- Shared package `gba_video_pkg`:
  - `GBA_WIDTH` = 240 and `GBA_HEIGHT` = 160.
  - Typedefs `bgr555_t` and `rgb6_t`.
  - Function `bgr555_to_rgb6`, which carries the darkening ifdef.
- Sub-module `gba_lcd_fifo`: synchronous FIFO with parameters WIDTH=16 and DEPTH=FIFO_DEPTH, a registered count, and full/empty flags. Distributed RAM.
- The top holds the position counters, the sof check and the output register.

## Test plan
- Single pixel after reset: `in_data` = 15'h7FFF, `in_sof` = 1 at cycle t.
  - Required: `pixel_we` at t+2 with x=0, y=0, `pixel_data` = 18'h3FFFF; with the macro, {56,56,56}.
- Full frame: 38400 pixels back-to-back, sof on the first.
  - Required: the last write is at (239,159); `frame_done` pulses exactly once; a following sof pixel writes at (0,0); `resync_err` stays 0.
- Backpressure: `sink_busy` = 1 for 100 cycles while streaming.
  - Required: `in_ready` drops after 16 accepts.
  - Required: no `pixel_we` except the one in flight; after release, 16 writes in order with no gaps.
- Mid-frame sof: sof on pixel 500.
  - Required: that pixel writes at (0,0) and `resync_err` = 1 from the same cycle onward.
- Colour mapping: `in_data` = {B=5'd1, G=5'd16, R=5'd0}.
  - Required: `pixel_data` R=0, G=33, B=2 (no macro).
- Reset mid-frame: reset at pixel 1000 with 8 pixels queued.
  - Required: no writes after reset and the FIFO is empty; the next unmarked pixel writes at (0,0).
